// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the game datapath.
// Runs load (INPUT) and read (IREAD) bursts of CYCLE_LEN cycles, each closed by
// a single WRITEOUT cycle. It counts completed rounds up to WIN_ROUNDS and then
// parks in WIN. An internal gap timer holds off IREAD for GAP_CYCLES cycles
// after reset or after a WRITEOUT.
// Optional build macro WAIT_TIMEOUT_EN: when defined, a stay in WAIT that lasts
// TIMEOUT_CYCLES cycles ends in LOSE.
module game_round_ctrl #(
  parameter int CYCLE_LEN      = 16,
  parameter int COUNT_W        = 4,
  parameter int WIN_ROUNDS     = 50,
  parameter int ROUND_W        = 9,
  parameter int GAP_CYCLES     = 8,
  parameter int GAP_W          = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic               clka,
  input  logic               reset,
  input  logic               inp,
  input  logic               run,
  input  logic               wai,
  input  logic               lose_sig,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] count,
  output logic [ROUND_W-1:0] rounds,
  output logic               gap_done,
  output logic               load_data,
  output logic               read_data,
  output logic               write_data,
  output logic               writeout,
  output logic               restart,
  output logic               win,
  output logic               lose
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_WIN      = 3'b001,
    ST_INPUT    = 3'b010,
    ST_IREAD    = 3'b011,
    ST_WRITEOUT = 3'b100,
    ST_WAIT     = 3'b101,
    ST_LOSE     = 3'b110,
    ST_RESTART  = 3'b111
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(CYCLE_LEN - 1);
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
  localparam logic [ROUND_W:0]   RND_ONE  = (ROUND_W + 1)'(1);
  localparam logic [ROUND_W:0]   RND_WIN  = (ROUND_W + 1)'(WIN_ROUNDS);
  localparam logic [GAP_W-1:0]   GAP_MAX  = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0]   GAP_ONE  = GAP_W'(1);

  // Decode order: {load_data, read_data, write_data, writeout, restart, win, lose}
  localparam logic [6:0] DEC_RESTART = 7'b0000100;

  // Decode a state code into the seven Moore output strobes.
  function automatic logic [6:0] decode_state(input state_t s);
    logic [6:0] d;
    d = 7'b0000000;
    case (s)
      ST_INPUT:    d = 7'b1010000;
      ST_IREAD:    d = 7'b0110000;
      ST_WRITEOUT: d = 7'b0001000;
      ST_RESTART:  d = 7'b0000100;
      ST_WIN:      d = 7'b0000010;
      ST_LOSE:     d = 7'b0000001;
      default:     d = 7'b0000000;
    endcase
    return d;
  endfunction

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [ROUND_W-1:0] rounds_q, rounds_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               gap_done_q, gap_done_d;
  logic [6:0]         dec_q, dec_d;
  logic [ROUND_W:0]   rounds_inc_s;
  logic               reach_win_s;
  logic               in_burst_s;
  logic               wait_timeout_s;

  assign rounds_inc_s = {1'b0, rounds_q} + RND_ONE;
  assign reach_win_s  = (rounds_inc_s >= RND_WIN);
  assign in_burst_s   = (state_q == ST_INPUT) || (state_q == ST_IREAD);

`ifdef WAIT_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TO_ONE  = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] to_q, to_d;

  assign wait_timeout_s = (to_q == TO_LAST);

  // The timeout counter restarts on every entry to WAIT and counts while the FSM stays there.
  always_comb begin
    to_d = {TIMEOUT_W{1'b0}};
    if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
      if (to_q == TO_LAST) begin
        to_d = to_q;
      end else begin
        to_d = to_q + TO_ONE;
      end
    end else begin
      to_d = {TIMEOUT_W{1'b0}};
    end
  end

  // Timeout counter register.
  always_ff @(posedge clka) begin
    if (reset) begin
      to_q <= {TIMEOUT_W{1'b0}};
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign wait_timeout_s = 1'b0;
`endif

  // Next-state logic; bursts ignore requests, and WIN and LOSE are left only by reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESTART: begin
        if (inp) begin
          state_d = ST_INPUT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (inp) begin
          state_d = ST_INPUT;
        end else if (run) begin
          if (lose_sig || wai || !gap_done_q) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IREAD;
          end
        end else if (wai) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INPUT, ST_IREAD: begin
        if (count_q == CNT_LAST) begin
          state_d = ST_WRITEOUT;
        end else begin
          state_d = state_q;
        end
      end
      ST_WRITEOUT: begin
        if (reach_win_s) begin
          state_d = ST_WIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lose_sig) begin
          state_d = ST_LOSE;
        end else if (!wai && gap_done_q) begin
          state_d = ST_IDLE;
        end else if (wait_timeout_s) begin
          state_d = ST_LOSE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WIN:  state_d = ST_WIN;
      ST_LOSE: state_d = ST_LOSE;
      default: state_d = ST_RESTART;
    endcase
  end

  // Burst index, round counter, gap timer and the registered output decodes.
  always_comb begin
    count_d    = {COUNT_W{1'b0}};
    rounds_d   = rounds_q;
    gap_d      = gap_q;
    gap_done_d = 1'b0;
    dec_d      = 7'b0000000;

    if (in_burst_s && (count_q != CNT_LAST)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = {COUNT_W{1'b0}};
    end

    if (state_q == ST_WRITEOUT) begin
      if (reach_win_s) begin
        rounds_d = RND_WIN[ROUND_W-1:0];
      end else begin
        rounds_d = rounds_inc_s[ROUND_W-1:0];
      end
      gap_d = {GAP_W{1'b0}};
    end else begin
      rounds_d = rounds_q;
      if (gap_q == GAP_MAX) begin
        gap_d = gap_q;
      end else begin
        gap_d = gap_q + GAP_ONE;
      end
    end

    gap_done_d = (gap_d == GAP_MAX);
    dec_d      = decode_state(state_d);
  end

  // State and datapath registers; reset returns the block to RESTART with everything cleared.
  always_ff @(posedge clka) begin
    if (reset) begin
      state_q    <= ST_RESTART;
      count_q    <= {COUNT_W{1'b0}};
      rounds_q   <= {ROUND_W{1'b0}};
      gap_q      <= {GAP_W{1'b0}};
      gap_done_q <= 1'b0;
      dec_q      <= DEC_RESTART;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rounds_q   <= rounds_d;
      gap_q      <= gap_d;
      gap_done_q <= gap_done_d;
      dec_q      <= dec_d;
    end
  end

  assign state      = state_q;
  assign count      = count_q;
  assign rounds     = rounds_q;
  assign gap_done   = gap_done_q;
  assign load_data  = dec_q[6];
  assign read_data  = dec_q[5];
  assign write_data = dec_q[4];
  assign writeout   = dec_q[3];
  assign restart    = dec_q[2];
  assign win        = dec_q[1];
  assign lose       = dec_q[0];

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed scoreboard bench for game_round_ctrl (WIN_ROUNDS=3, TIMEOUT_CYCLES=10).
module tb_game_round_ctrl;

  localparam int CYC   = 16;
  localparam int WIN_R = 3;
  localparam int GAP   = 8;
  localparam int TOC   = 10;

  localparam logic [2:0] S_IDLE     = 3'b000;
  localparam logic [2:0] S_WIN      = 3'b001;
  localparam logic [2:0] S_INPUT    = 3'b010;
  localparam logic [2:0] S_IREAD    = 3'b011;
  localparam logic [2:0] S_WRITEOUT = 3'b100;
  localparam logic [2:0] S_WAIT     = 3'b101;
  localparam logic [2:0] S_LOSE     = 3'b110;
  localparam logic [2:0] S_RESTART  = 3'b111;

  logic       clka = 1'b0;
  logic       reset, inp, run, wai, lose_sig;
  logic [2:0] state;
  logic [3:0] count;
  logic [8:0] rounds;
  logic       gap_done, load_data, read_data, write_data, writeout, restart, win, lose;

  always #5 clka = ~clka;

  game_round_ctrl #(
    .WIN_ROUNDS(WIN_R),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clka(clka), .reset(reset), .inp(inp), .run(run), .wai(wai), .lose_sig(lose_sig),
    .state(state), .count(count), .rounds(rounds), .gap_done(gap_done),
    .load_data(load_data), .read_data(read_data), .write_data(write_data),
    .writeout(writeout), .restart(restart), .win(win), .lose(lose)
  );

  typedef struct {
    logic [2:0] st;
    int         cnt;
    int         rnd;
    logic       gd;
  } exp_t;

  exp_t       sb_q[$];
  int         n_total = 0;
  int         n_pass  = 0;
  int         step_no = 0;
  int         gap_m   = 0;
  logic [2:0] prev_st = S_RESTART;

  // Expected {load_data, read_data, write_data, writeout, restart, win, lose} for a state.
  function automatic logic [6:0] exp_dec(input logic [2:0] s);
    case (s)
      S_INPUT:    return 7'b1010000;
      S_IREAD:    return 7'b0110000;
      S_WRITEOUT: return 7'b0001000;
      S_RESTART:  return 7'b0000100;
      S_WIN:      return 7'b0000010;
      S_LOSE:     return 7'b0000001;
      default:    return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, expv);
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare after the edge.
  task automatic step(input logic r, input logic i, input logic ru, input logic w, input logic l,
                      input logic [2:0] es, input int ec, input int er);
    exp_t e;
    reset = r; inp = i; run = ru; wai = w; lose_sig = l;
    if (r) gap_m = 0;
    else if (prev_st == S_WRITEOUT) gap_m = 0;
    else if (gap_m < GAP) gap_m++;
    e.st = es; e.cnt = ec; e.rnd = er; e.gd = (gap_m == GAP);
    sb_q.push_back(e);
    prev_st = es;
    step_no++;
    @(posedge clka);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("state", {29'd0, state}, {29'd0, e.st});
      check("count", {28'd0, count}, e.cnt);
      check("rounds", {23'd0, rounds}, e.rnd);
      check("gap_done", {31'd0, gap_done}, {31'd0, e.gd});
      check("decodes", {25'd0, load_data, read_data, write_data, writeout, restart, win, lose},
            {25'd0, exp_dec(e.st)});
    end
  endtask

  // One full INPUT burst starting from IDLE/RESTART with r completed rounds; requests are
  // held high mid-burst and lose_sig is high on the edge leaving WRITEOUT.
  task automatic burst_input(input int r);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_INPUT, 0, r);
    for (int k = 1; k < CYC; k++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, S_INPUT, k, r);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_WRITEOUT, 0, r);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (r + 1 >= WIN_R) ? S_WIN : S_IDLE, 0, r + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then one load burst
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RESTART, 0, 0);
    burst_input(0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 0, 1);

    // run held from reset: WAIT until gap_done, then an IREAD burst
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RESTART, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, 0, 0);
    for (int k = 2; k <= 8; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_WAIT, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, 0, 0);
    for (int k = 0; k < CYC; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_IREAD, k, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_WRITEOUT, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 0, 1);

    // Three rounds reach WIN; WIN absorbs all inputs; reset clears rounds
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RESTART, 0, 0);
    burst_input(0);
    burst_input(1);
    burst_input(2);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, S_WIN, 0, WIN_R);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RESTART, 0, 0);

    // lose_sig in WAIT -> LOSE, held
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_IDLE, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_WAIT, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_WAIT, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_LOSE, 0, 0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, S_LOSE, 0, 0);

    // lose_sig beats the WAIT exit (wai falling with gap_done high)
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RESTART, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_IDLE, 0, 0);
    for (int k = 2; k <= 8; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_WAIT, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_LOSE, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_LOSE, 0, 0);

    // Reset at count 7 of IREAD abandons the burst and clears rounds
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RESTART, 0, 0);
    burst_input(0);
    for (int k = 0; k < GAP; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 0, 1);
    for (int k = 0; k <= 7; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_IREAD, k, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S_RESTART, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 0, 0);

    // wai held in WAIT: timeout to LOSE if built in, otherwise WAIT persists
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_RESTART, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_IDLE, 0, 0);
`ifdef WAIT_TIMEOUT_EN
    for (int k = 0; k < TOC; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_WAIT, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_LOSE, 0, 0);
`else
    for (int k = 0; k < 1000; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_WAIT, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
